// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM state type for the SPI flash game loader.
package spi_flash_pkg;

    localparam int unsigned ADDR_BITS  = 24;
    localparam int unsigned DUMMY_BITS = 8;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_PUSH,
        ST_CS_HOLD,
        ST_END
    } flash_state_e;

endpackage

// File: rtl/spi_flash_game_loader_spi_bit_engine.sv
// SPI mode-0 bit engine: SCK divider plus one 8-bit shift register shared by
// transmit (MSB out on the low half) and receive (MISO captured as SCK rises).
module spi_bit_engine #(
    parameter int unsigned SPI_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       bit_done_c
);

    localparam int unsigned DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       shreg;
    logic             half_end;

    assign half_end   = en && (div_cnt == DIV_W'(SPI_DIV - 1));
    assign bit_done_c = half_end && sck;
    assign rx_data    = shreg;

    // load restarts the bit at the beginning of a low half with the new MSB on MOSI
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            shreg   <= 8'h00;
        end else if (load) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            shreg   <= load_data;
            mosi    <= load_data[7];
        end else if (en) begin
            if (half_end) begin
                div_cnt <= '0;
                sck     <= !sck;
                if (!sck) begin
                    shreg <= {shreg[6:0], miso};
                end else begin
                    mosi <= shreg[7];
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_flash_game_loader.sv
// Loads one game slot from SPI flash and streams its bytes to NES memory.
// Build option FLASH_FAST_READ_EN selects opcode 0x0B with 8 dummy clocks.
module spi_flash_game_loader
    import spi_flash_pkg::*;
#(
    parameter int unsigned           SPI_DIV    = 2,
    parameter int unsigned           GAME_W     = 3,
    parameter int unsigned           SLOT_SHIFT = 20,
    parameter logic [ADDR_BITS-1:0]  FLASH_BASE = 24'h200000,
    parameter int unsigned           LEN_W      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [GAME_W-1:0] game_sel,
    input  logic [LEN_W-1:0]  load_len,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              flash_csn,
    output logic              flash_sck,
    output logic              flash_mosi,
    input  logic              flash_miso
);

    localparam int unsigned DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE    = OP_FAST_READ;
    localparam bit         FAST_READ = 1'b1;
`else
    localparam logic [7:0] OPCODE    = OP_READ;
    localparam bit         FAST_READ = 1'b0;
`endif

    flash_state_e          state, state_next;
    logic [4:0]            bit_cnt;
    logic [DIV_W-1:0]      hold_cnt;
    logic [ADDR_BITS-1:0]  addr_sr;
    logic [LEN_W-1:0]      remaining;

    logic                  accept;
    logic                  eng_en;
    logic                  eng_load;
    logic [7:0]            eng_data;
    logic [7:0]            eng_rx;
    logic                  bit_done;
    logic                  hold_last;

    assign accept    = (state == ST_IDLE) && start && !done;
    assign hold_last = (hold_cnt == DIV_W'(SPI_DIV - 1));

    spi_bit_engine #(
        .SPI_DIV (SPI_DIV)
    ) u_engine (
        .clk        (clk),
        .reset      (reset),
        .en         (eng_en),
        .load       (eng_load),
        .load_data  (eng_data),
        .miso       (flash_miso),
        .sck        (flash_sck),
        .mosi       (flash_mosi),
        .rx_data    (eng_rx),
        .bit_done_c (bit_done)
    );

    // Next state plus engine control; each phase loads the next byte at its last bit
    always_comb begin
        state_next = state;
        eng_en     = 1'b0;
        eng_load   = 1'b0;
        eng_data   = 8'h00;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (load_len == '0) ? ST_END : ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (hold_last) begin
                    state_next = ST_CMD;
                    eng_load   = 1'b1;
                    eng_data   = OPCODE;
                end
            end
            ST_CMD: begin
                eng_en = 1'b1;
                if (bit_done && bit_cnt[2:0] == 3'd7) begin
                    state_next = ST_ADDR;
                    eng_load   = 1'b1;
                    eng_data   = addr_sr[ADDR_BITS-1 -: 8];
                end
            end
            ST_ADDR: begin
                eng_en = 1'b1;
                if (bit_done && bit_cnt[2:0] == 3'd7) begin
                    eng_load = 1'b1;
                    if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                        state_next = FAST_READ ? ST_DUMMY : ST_DATA;
                    end else begin
                        eng_data = addr_sr[ADDR_BITS-1 -: 8];
                    end
                end
            end
            ST_DUMMY: begin
                eng_en = 1'b1;
                if (bit_done && bit_cnt == 5'(DUMMY_BITS - 1)) begin
                    state_next = ST_DATA;
                    eng_load   = 1'b1;
                end
            end
            ST_DATA: begin
                eng_en = 1'b1;
                if (bit_done && bit_cnt == 5'd7) begin
                    state_next = ST_PUSH;
                    eng_load   = 1'b1;
                end
            end
            ST_PUSH: begin
                if (mem_ready) begin
                    state_next = (remaining == LEN_W'(1)) ? ST_CS_HOLD : ST_DATA;
                end
            end
            ST_CS_HOLD: begin
                if (hold_last) begin
                    state_next = ST_END;
                end
            end
            ST_END: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs; busy drops as done rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_csn <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= 8'h00;
        end else begin
            flash_csn <= (state_next == ST_IDLE) || (state_next == ST_END);
            busy      <= (state_next != ST_IDLE);
            done      <= (state == ST_END);
            mem_valid <= (state_next == ST_PUSH);
            if (accept) begin
                mem_addr <= '0;
            end else if (state == ST_PUSH && mem_ready) begin
                mem_addr <= mem_addr + LEN_W'(1);
            end
            if (state == ST_DATA && state_next == ST_PUSH) begin
                mem_data <= eng_rx;
            end
        end
    end

    // Transfer bookkeeping: slot address, byte countdown, bit and half-period counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_sr   <= '0;
            remaining <= '0;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            if (accept) begin
                addr_sr   <= FLASH_BASE + (ADDR_BITS'(game_sel) << SLOT_SHIFT);
                remaining <= load_len;
            end else begin
                if (eng_load && (state == ST_CMD || state == ST_ADDR)) begin
                    addr_sr <= addr_sr << 8;
                end
                if (state == ST_PUSH && mem_ready) begin
                    remaining <= remaining - LEN_W'(1);
                end
            end
            if (bit_done) begin
                bit_cnt <= (state_next != state) ? 5'd0 : bit_cnt + 5'd1;
            end
            if ((state == ST_CS_SETUP || state == ST_CS_HOLD) && state_next == state) begin
                hold_cnt <= hold_cnt + DIV_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule
